// File: rtl/mux_nto1_hs_if.sv
// Stream bundle for the N:1 handshake mux: CH input streams, one output stream,
// and the channel-selection controls. The mux uses the slave view.
interface mux_nto1_hs_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  localparam int SELW = $clog2(CH);

  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_nto1_hs.sv
// Registered CH:1 stream mux with fixed-select or round-robin arbitration.
// Optional handshake counter port xfer_cnt is built when MUXN_XFER_CNT_EN is defined.
module mux_nto1_hs #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MUXN_XFER_CNT_EN
  output logic [15:0] xfer_cnt,
`endif
  mux_nto1_hs_if.slave bus
);
  localparam int SELW = $clog2(CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] rr_q, rr_d;

  logic            load_en;
  logic            sel_ok;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;
  logic            xfer;
  logic [W-1:0]    ch_data [CH];

  // rst_n gates ready so no channel sees a handshake while reset is held.
  assign load_en = rst_n && (!out_valid_q || bus.out_ready);

  // Fixed mode offers ready on the selected channel regardless of its valid.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign ch_data[gi]      = bus.in_data[gi*W +: W];
      assign bus.in_ready[gi] = load_en &&
          (bus.mode ? (grant_vld && (grant_idx == SELW'(gi)))
                    : (sel_ok && (bus.sel == SELW'(gi))));
    end
  endgenerate

  always_comb begin
    sel_ok    = 1'b0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.sel == SELW'(i)) sel_ok = 1'b1;
    end
    if (!bus.mode) begin
      for (int i = 0; i < CH; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // Scan from farthest to nearest so the channel closest to rr_q wins.
      for (int k = CH - 1; k >= 0; k--) begin
        if (bus.in_valid[(int'(rr_q) + k) % CH]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'((int'(rr_q) + k) % CH);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SELW'(i)) grant_data = ch_data[i];
    end
  end

  assign xfer = load_en && grant_vld;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_valid_d = 1'b1;
      out_ch_d    = grant_idx;
      if (bus.mode) rr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_q        <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_q        <= rr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

`ifdef MUXN_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_mux_nto1_hs.sv
// Self-checking bench for mux_nto1_hs: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the output register.
module tb_mux_nto1_hs;
  localparam int CH = 4;
  localparam int W  = 8;

  logic clk;
  logic rst_n;
`ifdef MUXN_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  mux_nto1_hs_if #(.CH(CH), .W(W)) bus ();

  mux_nto1_hs #(.CH(CH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef MUXN_XFER_CNT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: contents of the output register and the fairness pointer.
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_ch;
  int          m_rr;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_rr = 0; m_cnt = 0;
  endtask

  // One clock: check the current cycle at negedge, then advance the model past the edge.
  task automatic step();
    logic [CH-1:0] e_ready;
    bit            load;
    int            g;
    int            sel_i;
    bit            n_valid;
    logic [W-1:0]  n_data;
    int            n_ch, n_rr, n_cnt;
    @(negedge clk);
    sel_i = int'(bus.sel);
    load  = !m_valid || bus.out_ready;
    g     = -1;
    if (!bus.mode) begin
      if (sel_i < CH && bus.in_valid[sel_i]) g = sel_i;
    end else begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_rr + k) % CH;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    e_ready = '0;
    if (load) begin
      if (!bus.mode) begin
        if (sel_i < CH) e_ready[sel_i] = 1'b1;
      end else if (g >= 0) begin
        e_ready[g] = 1'b1;
      end
    end
    chk("in_ready",  32'(bus.in_ready),  32'(e_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
`ifdef MUXN_XFER_CNT_EN
    chk("xfer_cnt",  32'(xfer_cnt),      32'(m_cnt));
`endif
    n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_rr = m_rr; n_cnt = m_cnt;
    if (m_valid && bus.out_ready && m_cnt < 16'hFFFF) n_cnt = m_cnt + 1;
    if (load && g >= 0) begin
      n_valid = 1; n_data = bus.in_data[g*W +: W]; n_ch = g;
      if (bus.mode) n_rr = (g + 1) % CH;
    end else if (m_valid && bus.out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_rr = n_rr; m_cnt = n_cnt;
  endtask

  task automatic drive(input bit md, input int s, input logic [CH-1:0] v,
                       input logic [CH*W-1:0] d, input bit ordy);
    bus.mode = md; bus.sel = s[$clog2(CH)-1:0]; bus.in_valid = v;
    bus.in_data = d; bus.out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(1, 0, 4'b1111, 32'h44332211, 1);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed select of channel 2
    drive(0, 2, 4'b0100, 32'h00A50000, 1);
    #1 chk("fix_in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    chk("fix_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fix_out_data",  32'(bus.out_data),  32'hA5);
    chk("fix_out_ch",    32'(bus.out_ch),    32'd2);

    // Backpressure: register full, consumer stalled
    drive(0, 2, 4'b0100, 32'h005A0000, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", 32'(bus.out_data), 32'hA5);
    end
    drive(0, 1, 4'b0010, 32'h00003C00, 1);
    step();
    chk("bp_refill_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_refill_data",  32'(bus.out_data),  32'h3C);
    chk("bp_refill_ch",    32'(bus.out_ch),    32'd1);

    // Round-robin over four always-valid channels
    drive(1, 0, 4'b1111, 32'hD4C3B2A1, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_all_ch",    32'(bus.out_ch),    32'(k % 4));
      chk("rr_all_valid", 32'(bus.out_valid), 32'd1);
    end

    // Only channels 1 and 3, pointer now at 2
    drive(1, 0, 4'b1010, 32'h33002200, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_sparse_ch", 32'(bus.out_ch), (k % 2 == 0) ? 32'd3 : 32'd1);
    end

    // Fixed mode on an idle channel: no transfers, pointer untouched
    drive(0, 0, 4'b1010, 32'h33002200, 1);
    repeat (3) step();
    chk("fix_idle_valid", 32'(bus.out_valid), 32'd0);
    drive(1, 0, 4'b1010, 32'h33002200, 1);
    step();
    chk("rr_resume_ch", 32'(bus.out_ch), 32'd3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, CH - 1),
            CH'($urandom), {$urandom}, ($urandom % 4) != 0);
      step();
    end

`ifdef MUXN_XFER_CNT_EN
    // Counter saturation
    drive(1, 0, 4'b1111, 32'h12345678, 1);
    step();
    force dut.xfer_cnt_q = 16'hFFFE;
    #1 release dut.xfer_cnt_q;
    m_cnt = 16'hFFFE;
    repeat (4) step();
    chk("cnt_saturated", 32'(xfer_cnt), 32'hFFFF);
`endif

    // Asynchronous reset while holding a word
    drive(1, 0, 4'b1111, 32'h99887766, 0);
    repeat (2) step();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'd0);
    chk("arst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 4'b1111, 32'h99887766, 1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mux_nto1_hs.md
Name: mux_nto1_hs

Overview:
- Parametrised, registered N-channel to 1 multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the 4:1 single-bit select mux to CH channels of W bits.
- Two channel-selection modes:
  - fixed: external select.
  - round-robin: fair arbitration among valid channels.
- Sits between multiple producer streams and a single consumer. Output is registered with 1-cycle latency.

Parameters:
- CH, 4, number of input channels (2..16).
- W, 8, data width per channel (1..64).
- SELW, $clog2(CH), localparam; width of sel and out_ch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  CH*W  channel i occupies bits [i*W +: W]
- in_valid  in  CH  per-channel valid
- in_ready  out  CH  per-channel ready (one-hot or zero)
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- out_data  out  W  registered selected data
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts
- out_ch  out  SELW  index of the channel that supplied out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready=0 while rst_n low.
- Output register: one entry.
  - load_en = !out_valid || out_ready.
  - Drain and refill in the same cycle are allowed, giving full throughput of 1 word/cycle.
- Grant (combinational, computed every cycle):
  - mode=0: grant = sel if sel<CH and in_valid[sel]; otherwise no grant.
  - sel>=CH (non-power-of-2 CH): no grant, and every in_ready=0.
  - mode=1: grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo CH. No valid channel means no grant.
- in_ready[i] = load_en && grant==i. At most one bit set. In fixed mode, in_ready[sel] may be 1 while in_valid[sel]=0 (ready does not depend on that channel's valid).
- Transfer on channel i: in_valid[i] && in_ready[i]. On that edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- No transfer, but out_valid && out_ready: out_valid <= 0. out_data and out_ch hold their values.
- Neither transfer nor drain: output register holds. out_data must stay stable while out_valid && !out_ready.
- rr_ptr:
  - Updates only on a mode=1 transfer: rr_ptr <= (grant==CH-1) ? 0 : grant+1.
  - Unchanged in mode=0.
  - Preserved across mode switches.
- Mode and sel changes take effect at the next grant evaluation. They never disturb data already held in the output register.
- Latency: input transfer to out_valid is exactly 1 cycle.
- Reset mid-operation: any held word is discarded immediately and asynchronously.

Optional Feature:
- Macro MUXN_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt (16 bits), which counts completed output handshakes (out_valid && out_ready).
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then mode=0, sel=2, W=8, ch2 data=8'hA5 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Backpressure: out_ready=0 with output full -> in_ready=0, out_data held for 5 cycles. Raise out_ready with ch1 valid (sel=1) -> drain and refill in the same cycle; out_valid stays 1.
- mode=1, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, 1 word per cycle.
- mode=1, only ch1 and ch3 valid, rr_ptr=2 -> grant order 3,1,3,1. Switch to mode=0, sel=0 with ch0 invalid -> no transfers; rr_ptr still intact on return to mode=1.
- Assert rst_n=0 asynchronously mid-burst with out_valid=1 -> out_valid, out_data, out_ch and in_ready go to 0 before the next clk edge.
- With MUXN_XFER_CNT_EN defined, 10 output handshakes -> xfer_cnt=10. Force the counter to 16'hFFFE, then 3 handshakes -> xfer_cnt=16'hFFFF.
